// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath.
// Light indices select one of four lamps; the LFSR supplies them pseudo-randomly.
package simon_pkg;

    localparam int N_LIGHTS = 4;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef logic [1:0] light_idx_t;

    function automatic logic [N_LIGHTS-1:0] onehot(light_idx_t idx);
        logic [N_LIGHTS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/simon_sat_cnt.sv
// Saturating up-counter: clr has priority over en, holds at MAX instead of wrapping.
// Output is the registered count; a strobe at edge k shows in q after edge k.
module simon_sat_cnt #(
    parameter int MAX = 49,
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != W'(MAX))) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: timers, score/step counters, replayable LFSR light sequence,
// switch synchroniser and LED mux. Status flags decode registered state only.
module simon_datapath
    import simon_pkg::*;
#(
    parameter int          TIMER_MAX  = 49,
    parameter int          TIMER_GTN  = 2,
    parameter int          UTIMER_MAX = 199,
    parameter int          SCORE_W    = 5,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timerCntEn,
    input  logic               timerRst,
    input  logic               uTimerCntEn,
    input  logic               uTimerRst,
    input  logic               scoreCntEn,
    input  logic               scoreCntRst,
    input  logic               seqCntEn,
    input  logic               seqCntRst,
    input  logic               rndSeqEn,
    input  logic               rndSeqRst,
    input  logic               lightAllSl,
    input  logic               lightRndSl,
    input  logic [3:0]         sw,
    output logic               timerGtN,
    output logic               timerOut,
    output logic               uTimerOut,
    output logic               seqEqScore,
    output logic               anySwitch,
    output logic               switchMatch,
    output logic [3:0]         leds,
    output logic [SCORE_W-1:0] score
);

    localparam int TW  = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);
    localparam int UTW = (UTIMER_MAX < 1) ? 1 : $clog2(UTIMER_MAX + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    logic [TW-1:0]       timerQ;
    logic [UTW-1:0]      uTimerQ;
    logic [SCORE_W-1:0]  scoreQ;
    logic [SCORE_W-1:0]  seqQ;
    logic [15:0]         lfsr;
    logic [N_LIGHTS-1:0] swMeta;
    logic [N_LIGHTS-1:0] swS;
    logic [N_LIGHTS-1:0] expLight;

    simon_sat_cnt #(.MAX(TIMER_MAX)) uTimerCnt (
        .clk (clk), .rst (rst), .clr (timerRst), .en (timerCntEn), .q (timerQ)
    );

    simon_sat_cnt #(.MAX(UTIMER_MAX)) uUserTimerCnt (
        .clk (clk), .rst (rst), .clr (uTimerRst), .en (uTimerCntEn), .q (uTimerQ)
    );

    simon_sat_cnt #(.MAX(SCORE_MAX)) uScoreCnt (
        .clk (clk), .rst (rst), .clr (scoreCntRst), .en (scoreCntEn), .q (scoreQ)
    );

    simon_sat_cnt #(.MAX(SCORE_MAX)) uSeqCnt (
        .clk (clk), .rst (rst), .clr (seqCntRst), .en (seqCntEn), .q (seqQ)
    );

    // Galois right-shift LFSR; reloading SEED replays the same light sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (rndSeqRst) begin
            lfsr <= SEED;
        end else if (rndSeqEn) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swMeta <= '0;
            swS    <= '0;
        end else begin
            swMeta <= sw;
            swS    <= swMeta;
        end
    end

    assign expLight = onehot(light_idx_t'(lfsr[1:0]));

    assign timerGtN    = (timerQ > TW'(TIMER_GTN));
    assign timerOut    = (timerQ == TW'(TIMER_MAX));
    assign uTimerOut   = (uTimerQ == UTW'(UTIMER_MAX));
    assign seqEqScore  = (seqQ == scoreQ);
    assign anySwitch   = |swS;
    assign switchMatch = (swS == expLight);
    assign score       = scoreQ;

    always_comb begin
        leds = swS;
        if (lightAllSl) begin
            leds = 4'b1111;
        end else if (lightRndSl) begin
            leds = expLight;
        end
    end

endmodule

// File: tb/tb_simon_datapath.sv
// Directed test of simon_datapath with hand-computed expected values.
module tb_simon_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       timerCntEn, timerRst, uTimerCntEn, uTimerRst;
    logic       scoreCntEn, scoreCntRst, seqCntEn, seqCntRst;
    logic       rndSeqEn, rndSeqRst, lightAllSl, lightRndSl;
    logic [3:0] sw;
    logic       timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch;
    logic [3:0] leds;
    logic [4:0] score;

    int nChecks = 0;
    int nErrors = 0;

    // LED one-hot seen after reset and after each of 5 shifts from seed ACE1
    logic [3:0] seqLeds [0:5];
    logic [3:0] firstPass [0:5];

    simon_datapath dut (
        .clk (clk), .rst (rst),
        .timerCntEn (timerCntEn), .timerRst (timerRst),
        .uTimerCntEn (uTimerCntEn), .uTimerRst (uTimerRst),
        .scoreCntEn (scoreCntEn), .scoreCntRst (scoreCntRst),
        .seqCntEn (seqCntEn), .seqCntRst (seqCntRst),
        .rndSeqEn (rndSeqEn), .rndSeqRst (rndSeqRst),
        .lightAllSl (lightAllSl), .lightRndSl (lightRndSl),
        .sw (sw),
        .timerGtN (timerGtN), .timerOut (timerOut), .uTimerOut (uTimerOut),
        .seqEqScore (seqEqScore), .anySwitch (anySwitch), .switchMatch (switchMatch),
        .leds (leds), .score (score)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        seqLeds[0] = 4'b0010; // ACE1 -> idx 1
        seqLeds[1] = 4'b0001; // E270 -> idx 0
        seqLeds[2] = 4'b0001; // 7138 -> idx 0
        seqLeds[3] = 4'b0001; // 389C -> idx 0
        seqLeds[4] = 4'b0100; // 1C4E -> idx 2
        seqLeds[5] = 4'b1000; // 0E27 -> idx 3

        rst = 1'b1;
        {timerCntEn, timerRst, uTimerCntEn, uTimerRst} = '0;
        {scoreCntEn, scoreCntRst, seqCntEn, seqCntRst} = '0;
        {rndSeqEn, rndSeqRst, lightAllSl, lightRndSl} = '0;
        sw = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(1);

        chk("rst_timerGtN", 32'(timerGtN), 0);
        chk("rst_timerOut", 32'(timerOut), 0);
        chk("rst_uTimerOut", 32'(uTimerOut), 0);
        chk("rst_seqEqScore", 32'(seqEqScore), 1);
        chk("rst_anySwitch", 32'(anySwitch), 0);
        chk("rst_switchMatch", 32'(switchMatch), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_score", 32'(score), 0);

        // Timer: enabled every edge, count == number of enabled edges
        timerCntEn = 1'b1;
        tick(2);
        chk("timer_gtn_at2", 32'(timerGtN), 0);
        tick(1);
        chk("timer_gtn_at3", 32'(timerGtN), 1);
        tick(45);
        chk("timer_out_at48", 32'(timerOut), 0);
        tick(1);
        chk("timer_out_at49", 32'(timerOut), 1);
        tick(10);
        chk("timer_out_sat", 32'(timerOut), 1);
        timerRst = 1'b1;
        tick(1);
        timerRst = 1'b0;
        timerCntEn = 1'b0;
        chk("timer_rst_pri_gtn", 32'(timerGtN), 0);
        chk("timer_rst_pri_out", 32'(timerOut), 0);

        // User timer terminal count
        uTimerCntEn = 1'b1;
        tick(198);
        chk("utimer_at198", 32'(uTimerOut), 0);
        tick(1);
        chk("utimer_at199", 32'(uTimerOut), 1);
        tick(3);
        chk("utimer_sat", 32'(uTimerOut), 1);
        uTimerCntEn = 1'b0;
        uTimerRst = 1'b1;
        tick(1);
        uTimerRst = 1'b0;
        chk("utimer_clr", 32'(uTimerOut), 0);

        // Replay: first pass against hand values, second pass against first
        lightRndSl = 1'b1;
        rndSeqRst = 1'b1;
        tick(1);
        rndSeqRst = 1'b0;
        firstPass[0] = leds;
        chk("seq_step0", 32'(leds), 32'(seqLeds[0]));
        for (int i = 1; i <= 5; i++) begin
            rndSeqEn = 1'b1;
            tick(1);
            rndSeqEn = 1'b0;
            firstPass[i] = leds;
            chk($sformatf("seq_step%0d", i), 32'(leds), 32'(seqLeds[i]));
        end
        rndSeqRst = 1'b1;
        rndSeqEn = 1'b1;
        tick(1);
        rndSeqEn = 1'b0;
        rndSeqRst = 1'b0;
        chk("replay_rst_pri", 32'(leds), 32'(firstPass[0]));
        for (int i = 1; i <= 5; i++) begin
            rndSeqEn = 1'b1;
            tick(1);
            rndSeqEn = 1'b0;
            chk($sformatf("replay_step%0d", i), 32'(leds), 32'(firstPass[i]));
        end
        lightRndSl = 1'b0;

        // Move to expected index 2 (four shifts from seed)
        rndSeqRst = 1'b1;
        tick(1);
        rndSeqRst = 1'b0;
        rndSeqEn = 1'b1;
        tick(4);
        rndSeqEn = 1'b0;
        sw = 4'b0100;
        tick(1);
        chk("match_after1", 32'(switchMatch), 0);
        tick(1);
        chk("match_after2", 32'(switchMatch), 1);
        chk("echo_leds", 32'(leds), 32'h4);
        sw = 4'b0110;
        tick(2);
        chk("two_sw_match", 32'(switchMatch), 0);
        chk("two_sw_any", 32'(anySwitch), 1);

        // LED priority
        sw = 4'b0001;
        lightAllSl = 1'b1;
        lightRndSl = 1'b1;
        tick(2);
        chk("led_all", 32'(leds), 32'hF);
        lightAllSl = 1'b0;
        #1;
        chk("led_rnd", 32'(leds), 32'h4);
        lightRndSl = 1'b0;
        #1;
        chk("led_echo", 32'(leds), 32'h1);
        sw = 4'b0000;

        // Score and step counters
        scoreCntEn = 1'b1;
        tick(3);
        scoreCntEn = 1'b0;
        chk("score_3", 32'(score), 3);
        seqCntRst = 1'b1;
        tick(1);
        seqCntRst = 1'b0;
        seqCntEn = 1'b1;
        tick(1);
        chk("seq_eq_1", 32'(seqEqScore), 0);
        tick(1);
        chk("seq_eq_2", 32'(seqEqScore), 0);
        tick(1);
        seqCntEn = 1'b0;
        chk("seq_eq_3", 32'(seqEqScore), 1);
        scoreCntEn = 1'b1;
        tick(40);
        scoreCntEn = 1'b0;
        chk("score_sat", 32'(score), 31);
        chk("seq_ne_sat", 32'(seqEqScore), 0);
        seqCntEn = 1'b1;
        tick(40);
        seqCntEn = 1'b0;
        chk("seq_eq_sat", 32'(seqEqScore), 1);

        // Async reset mid-count: timer 17, score 3, switches echoing
        scoreCntRst = 1'b1;
        timerRst = 1'b1;
        tick(1);
        scoreCntRst = 1'b0;
        timerRst = 1'b0;
        timerCntEn = 1'b1;
        scoreCntEn = 1'b1;
        tick(3);
        scoreCntEn = 1'b0;
        sw = 4'b1000;
        tick(14);
        chk("pre_rst_score", 32'(score), 3);
        chk("pre_rst_leds", 32'(leds), 32'h8);
        chk("pre_rst_gtn", 32'(timerGtN), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_score", 32'(score), 0);
        chk("async_rst_leds", 32'(leds), 0);
        chk("async_rst_gtn", 32'(timerGtN), 0);
        timerCntEn = 1'b0;
        sw = 4'b0000;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("post_rst_seqEqScore", 32'(seqEqScore), 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/simon_datapath.md
# simon_datapath

Datapath companion to the Simon game control state machine. Holds the Simon timer, user timer, score counter, sequence-step counter and the replayable pseudo-random light sequence. Executes the FSM's enable/reset strobes and returns the status flags the FSM branches on. Also synchronises the player switches and drives the game LEDs.

## Interface

- Reset: one clock; reset is asynchronous and active-high.

Parameters:
- `TIMER_MAX`, default 49, Simon timer terminal count.
- `TIMER_GTN`, default 2, threshold for `timerGtN`.
- `UTIMER_MAX`, default 199, user timer terminal count.
- `SCORE_W`, default 5, width of the score and step counters.
- `SEED`, default 16'hACE1, LFSR reload value; must be nonzero.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous active-high reset.
- `timerCntEn`, `timerRst`, in, 1 each, Simon timer controls.
- `uTimerCntEn`, `uTimerRst`, in, 1 each, user timer controls.
- `scoreCntEn`, `scoreCntRst`, in, 1 each, score controls.
- `seqCntEn`, `seqCntRst`, in, 1 each, step counter controls.
- `rndSeqEn`, `rndSeqRst`, in, 1 each, LFSR advance and reload.
- `lightAllSl`, `lightRndSl`, in, 1 each, LED source selects.
- `sw`, in, 4, raw player switches, asynchronous to `clk`.
- `timerGtN`, out, 1, Simon timer count is greater than `TIMER_GTN`.
- `timerOut`, out, 1, Simon timer count equals `TIMER_MAX`.
- `uTimerOut`, out, 1, user timer count equals `UTIMER_MAX`.
- `seqEqScore`, out, 1, step count equals score.
- `anySwitch`, out, 1, any synchronised switch is high.
- `switchMatch`, out, 1, synchronised switches equal the expected one-hot light.
- `leds`, out, 4, game lights.
- `score`, out, `SCORE_W`, current score, used for display.

## Operation

- **Counters** (timer, uTimer, score, seq):
  - Synchronous `*Rst` has priority over `*CntEn`.
  - An enabled counter increments by 1 and saturates at its maximum: `TIMER_MAX`, `UTIMER_MAX`, or 2^SCORE_W−1.
  - A counter holds its value when idle.
  - Timer widths are `$clog2(MAX+1)`.
- **LFSR:**
  - 16-bit Galois, taps 16'hB400.
  - `rndSeqRst` reloads `SEED` and has priority over `rndSeqEn`.
  - `rndSeqEn` shifts once.
  - Expected light index = `lfsr[1:0]`.
  - Reloading replays the identical sequence; this is how the FSM replays for the player.
- **Switches:**
  - Two-flop synchroniser on `sw`, producing `sw_s`.
  - `anySwitch = |sw_s`.
  - `switchMatch = (sw_s == 1 << lfsr[1:0])`.
  - Two or more switches pressed never matches.
- **LEDs,** in priority order:
  - `lightAllSl`: 4'b1111.
  - else `lightRndSl`: one-hot of `lfsr[1:0]`.
  - else `sw_s`, echoing the player's input.
- **Flags:** all status flags are combinational from registered state. No input-to-output combinational path exists except through the LED and flag muxes.

## Timing

- **Reset values:**
  - All counters 0.
  - LFSR = `SEED`.
  - Synchroniser flops 0.
  - So after reset: `timerGtN = 0`, `timerOut = 0`, `uTimerOut = 0`, `seqEqScore = 1`, `anySwitch = 0`, `switchMatch = 0`, `leds = 0`, `score = 0`.
- **Reset mid-operation:** asserting `rst` clears everything immediately. Deassertion is synchronised by the system.
- **Strobe latency:** a strobe sampled at edge k changes the counter or LFSR after edge k. Flags reflect the new value in cycle k+1.
- **Switch latency:** 2 cycles from a stable `sw` change to `anySwitch`, `switchMatch` and the echo on `leds`.
- **Simultaneous events:**
  - `*Rst` together with `*CntEn` gives 0, not 1.
  - `rndSeqRst` together with `rndSeqEn` gives `SEED`.
- **Saturation:**
  - `timerOut` stays high while the timer is enabled past `TIMER_MAX`. The counter does not wrap.
  - Score saturates at 31; at 31, `seqEqScore` is still evaluated normally.

## Structure

- **`simon_pkg`** holds:
  - `N_LIGHTS = 4`
  - `typedef logic [1:0] light_idx_t`
  - `LFSR_TAPS = 16'hB400`
  - `DEFAULT_SEED`
  - function `onehot(light_idx_t)`
- **Sub-module `simon_sat_cnt`:**
  - Parameterised `MAX`, width derived; ports `clk`, `rst`, `clr`, `en`, `q`.
  - Instantiated four times.
- LFSR and synchroniser are inline.

## Test plan

- **Reset:** assert `rst` mid-count with timer = 17, score = 3 → all counters 0 and `leds = 0` asynchronously; after release, `seqEqScore = 1`.
- **Timer:** hold `timerCntEn` → `timerGtN` rises when count = 3 (cycle 3 after enable); `timerOut` rises at count 49 and stays high for 10 more enabled cycles. `timerRst` + `timerCntEn` → count 0.
- **Replay:**
  - `rndSeqRst`, then 5× `rndSeqEn`, recording `lfsr[1:0]` each step.
  - `rndSeqRst` again and repeat → identical 5-index sequence.
  - `lightRndSl = 1` → `leds` one-hot matches each index.
- **Switch match:**
  - Expected index 2 and `sw = 4'b0100` → `switchMatch = 1` exactly 2 cycles later.
  - `sw = 4'b0110` → `switchMatch = 0`, `anySwitch = 1`.
- **Score/step:**
  - 3× `scoreCntEn` → `score = 3`.
  - `seqCntRst`, then 3× `seqCntEn` → `seqEqScore` high only after the third.
  - 40× `scoreCntEn` → `score = 31`.
- **LED priority:** `lightAllSl = 1`, `lightRndSl = 1`, `sw = 4'b0001` → `leds = 4'b1111`. Drop `lightAllSl` → one-hot expected. Drop both → `4'b0001`.
